uart_tx_cfg: RTL and testbench

Parametrised, configurable UART transmitter. It is the next generation of the fixed 8N1 transmitter.
- Adds: data width parameter, run-time baud divisor, parity modes, 1/2 stop bits, valid/ready input handshake, gap-free back-to-back frames.
- Optional transmit FIFO.
- Sits between a byte producer (command/trace logic) and the board RS-232 pin.

---
 rtl/uart_tx_cfg.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, run-time divisor, parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to insert a FIFO_DEPTH-word transmit FIFO in front of the frame FSM.
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Send_data,
    input  logic              Send_valid,
    output logic              Send_ready,
    input  logic [DIV_W-1:0]  Baud_div,
    input  logic [1:0]        Parity_mode,
    input  logic              Stop_two,
    output logic              Rs232_tx,
    output logic              Tx_Done,
    output logic              Busy
);

    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                stop_two_q, stop_two_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                tx_q, tx_d;

    logic                bit_end;
    logic                final_stop;
    logic                frame_free;
    logic                load;
    logic [DATA_W-1:0]   load_data;

    assign bit_end    = (baud_cnt_q == div_q);
    assign final_stop = (state_q == STOP) && bit_end && (stop_cnt_q == stop_two_q);
    // The FSM can take a new word in IDLE or in the very last clock of a frame.
    assign frame_free = (state_q == IDLE) || final_stop;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              full;
    logic              empty;
    logic              push;

    assign full       = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = Send_valid && !full;
    assign load       = frame_free && !empty;
    assign load_data  = mem_q[rd_ptr_q];
    assign Send_ready = !full;
    assign Busy       = (state_q != IDLE) || !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !load) count_d = count_q + (PTR_W+1)'(1);
        else if (!push && load) count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= Send_data;
    end
`else
    assign load       = Send_valid && frame_free;
    assign load_data  = Send_data;
    assign Send_ready = frame_free;
    assign Busy       = (state_q != IDLE);
`endif

    assign Tx_Done  = final_stop;
    assign Rs232_tx = tx_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        stop_two_d = stop_two_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;

        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);
        end

        case (state_q)
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_W-1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (final_stop) state_d = IDLE;
                else if (bit_end) stop_cnt_d = 1'b1;
            end
            default: ;
        endcase

        // A load overrides everything, including the return to IDLE after the last stop clock.
        if (load) begin
            state_d    = START;
            shreg_d    = load_data;
            div_d      = (Baud_div == '0) ? DIV_W'(1) : Baud_div;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            stop_two_d = Stop_two;
            par_en_d   = (Parity_mode != 2'd0);
            case (Parity_mode)
                2'd1:    par_bit_d = ^load_data;
                2'd2:    par_bit_d = ~^load_data;
                default: par_bit_d = 1'b1;
            endcase
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            div_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            stop_two_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            stop_two_q <= stop_two_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg; the FIFO scenario runs when UART_TX_FIFO_EN is defined.
module tb_uart_tx_cfg;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  Send_data;
    logic        Send_valid;
    logic        Send_ready;
    logic [15:0] Baud_div;
    logic [1:0]  Parity_mode;
    logic        Stop_two;
    logic        Rs232_tx;
    logic        Tx_Done;
    logic        Busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    uart_tx_cfg #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .Send_data(Send_data), .Send_valid(Send_valid), .Send_ready(Send_ready),
        .Baud_div(Baud_div), .Parity_mode(Parity_mode), .Stop_two(Stop_two),
        .Rs232_tx(Rs232_tx), .Tx_Done(Tx_Done), .Busy(Busy)
    );

    task automatic test_reset();
        Rst = 1'b1;
        Send_valid = 1'b0; Send_data = 8'h00;
        Baud_div = 16'd3; Parity_mode = 2'd0; Stop_two = 1'b0;
        repeat (2) @(negedge Clk);
        total_cnt++;
        if ({Rs232_tx, Tx_Done, Busy} !== 3'b100)
            $display("FAIL reset_outputs: tx/done/busy=%b%b%b expected 100", Rs232_tx, Tx_Done, Busy);
        else pass_cnt++;
        Rst = 1'b0;
        @(negedge Clk);
        total_cnt++;
        if ({Rs232_tx, Busy} !== 2'b10)
            $display("FAIL reset_release_idle: tx/busy=%b%b expected 10", Rs232_tx, Busy);
        else pass_cnt++;
    endtask

`ifndef UART_TX_FIFO_EN
    // Presents one word at a negedge and holds it across exactly one rising edge.
    task automatic do_accept(input logic [7:0] d, input logic [15:0] div,
                             input logic [1:0] pm, input logic st2, input string name);
        @(negedge Clk);
        Send_data = d; Baud_div = div; Parity_mode = pm; Stop_two = st2; Send_valid = 1'b1;
        total_cnt++;
        if (Send_ready !== 1'b1)
            $display("FAIL %s_ready: Send_ready=%b expected 1", name, Send_ready);
        else pass_cnt++;
        @(posedge Clk);
        #1 Send_valid = 1'b0;
    endtask

    // Called right after the accept edge; leaves the bench at the negedge of the Tx_Done clock.
    task automatic expect_frame(input logic [7:0] d, input int per, input bit par_en,
                                input bit par_bit, input bit st2, input string name);
        logic exp_bits[$];
        int n;
        int bad_tx = -1, bad_done = -1, bad_rdy = -1, bad_busy = -1;
        logic got_tx = 1'b0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (par_en) exp_bits.push_back(par_bit);
        exp_bits.push_back(1'b1);
        if (st2) exp_bits.push_back(1'b1);
        n = exp_bits.size() * per;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            if (bad_tx < 0 && Rs232_tx !== exp_bits[k / per]) begin
                bad_tx = k + 1; got_tx = Rs232_tx;
            end
            if (bad_done < 0 && Tx_Done !== (k == n - 1)) bad_done = k + 1;
            if (bad_rdy < 0 && Send_ready !== (k == n - 1)) bad_rdy = k + 1;
            if (bad_busy < 0 && Busy !== 1'b1) bad_busy = k + 1;
        end
        total_cnt++;
        if (bad_tx >= 0)
            $display("FAIL %s_line: clock %0d tx=%b expected %b", name, bad_tx, got_tx, exp_bits[(bad_tx-1)/per]);
        else pass_cnt++;
        total_cnt++;
        if (bad_done >= 0)
            $display("FAIL %s_done: Tx_Done wrong at clock %0d, expected pulse only at clock %0d", name, bad_done, n);
        else pass_cnt++;
        total_cnt++;
        if (bad_rdy >= 0)
            $display("FAIL %s_ready_in_frame: Send_ready wrong at clock %0d, expected 1 only at clock %0d", name, bad_rdy, n);
        else pass_cnt++;
        total_cnt++;
        if (bad_busy >= 0)
            $display("FAIL %s_busy: Busy=0 at clock %0d expected 1", name, bad_busy);
        else pass_cnt++;
    endtask

    task automatic check_idle(input string name);
        @(negedge Clk);
        total_cnt++;
        if ({Rs232_tx, Busy, Tx_Done} !== 3'b100)
            $display("FAIL %s_idle: tx/busy/done=%b%b%b expected 100", name, Rs232_tx, Busy, Tx_Done);
        else pass_cnt++;
    endtask

    task automatic test_basic_8n1();
        do_accept(8'hA5, 16'd3, 2'd0, 1'b0, "a5");
        expect_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, "a5");
        check_idle("a5");
    endtask

    task automatic test_parity_stop();
        do_accept(8'h07, 16'd1, 2'd1, 1'b0, "even07");
        expect_frame(8'h07, 2, 1'b1, 1'b1, 1'b0, "even07");
        check_idle("even07");
        do_accept(8'h07, 16'd1, 2'd2, 1'b0, "odd07");
        expect_frame(8'h07, 2, 1'b1, 1'b0, 1'b0, "odd07");
        check_idle("odd07");
        do_accept(8'h07, 16'd1, 2'd2, 1'b1, "odd07_stop2");
        expect_frame(8'h07, 2, 1'b1, 1'b0, 1'b1, "odd07_stop2");
        check_idle("odd07_stop2");
        do_accept(8'h00, 16'd1, 2'd3, 1'b0, "mark00");
        expect_frame(8'h00, 2, 1'b1, 1'b1, 1'b0, "mark00");
        check_idle("mark00");
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        Send_data = 8'h55; Baud_div = 16'd3; Parity_mode = 2'd0; Stop_two = 1'b0; Send_valid = 1'b1;
        @(posedge Clk);
        #1 Send_data = 8'h0F;
        expect_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, "b2b_first");
        @(posedge Clk);
        #1 Send_valid = 1'b0;
        expect_frame(8'h0F, 4, 1'b0, 1'b0, 1'b0, "b2b_second");
        check_idle("b2b");
    endtask

    task automatic test_divisor();
        do_accept(8'h96, 16'd0, 2'd0, 1'b0, "div0");
        expect_frame(8'h96, 2, 1'b0, 1'b0, 1'b0, "div0");
        check_idle("div0");
        do_accept(8'hC3, 16'd3, 2'd0, 1'b0, "div3");
        Baud_div = 16'd7; Parity_mode = 2'd1; Stop_two = 1'b1;
        expect_frame(8'hC3, 4, 1'b0, 1'b0, 1'b0, "div3_midchange");
        check_idle("div3");
        do_accept(8'hC3, 16'd7, 2'd0, 1'b0, "div7");
        expect_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, "div7");
        check_idle("div7");
    endtask

    task automatic test_reset_mid_frame();
        do_accept(8'hF0, 16'd3, 2'd0, 1'b0, "rst_frame");
        repeat (18) @(negedge Clk);
        total_cnt++;
        if (Rs232_tx !== 1'b0)
            $display("FAIL rst_pre_bit3: tx=%b expected 0", Rs232_tx);
        else pass_cnt++;
        Rst = 1'b1;
        #1;
        total_cnt++;
        if ({Rs232_tx, Busy, Tx_Done} !== 3'b100)
            $display("FAIL rst_async: tx/busy/done=%b%b%b expected 100", Rs232_tx, Busy, Tx_Done);
        else pass_cnt++;
        @(negedge Clk);
        Rst = 1'b0;
        do_accept(8'h3C, 16'd3, 2'd0, 1'b0, "after_rst");
        expect_frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, "after_rst");
        check_idle("after_rst");
    endtask
`else
    task automatic test_fifo();
        logic [7:0] words [5];
        logic samples [$];
        int done_cnt = 0;
        int f = -1;
        int bad = -1;
        logic e;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        Baud_div = 16'd3; Parity_mode = 2'd0; Stop_two = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    int t = 0;
                    @(negedge Clk);
                    Send_data = words[i]; Send_valid = 1'b1;
                    while (Send_ready !== 1'b1 && t < 400) begin
                        @(negedge Clk); t++;
                    end
                    @(posedge Clk);
                    #1;
                end
                Send_valid = 1'b0;
                @(negedge Clk);
                total_cnt++;
                if (Send_ready !== 1'b0)
                    $display("FAIL fifo_full_ready: Send_ready=%b expected 0", Send_ready);
                else pass_cnt++;
            end
            begin
                for (int k = 0; k < 250; k++) begin
                    @(negedge Clk);
                    samples.push_back(Rs232_tx);
                    if (Tx_Done === 1'b1) done_cnt++;
                end
            end
        join
        for (int k = 0; k < samples.size(); k++)
            if (f < 0 && samples[k] === 1'b0) f = k;
        total_cnt++;
        if (f < 0 || f > 10)
            $display("FAIL fifo_first_start: start bit at sample %0d expected within 10", f);
        else begin
            pass_cnt++;
            for (int j = 0; j < 240 - f; j++) begin
                int fr = j / 40;
                int b = (j % 40) / 4;
                if (fr >= 5) e = 1'b1;
                else if (b == 0) e = 1'b0;
                else if (b == 9) e = 1'b1;
                else e = words[fr][b-1];
                if (bad < 0 && samples[f + j] !== e) bad = j;
            end
            total_cnt++;
            if (bad >= 0)
                $display("FAIL fifo_stream: offset %0d tx=%b expected other level", bad, samples[f + bad]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt != 5)
            $display("FAIL fifo_done_count: %0d pulses expected 5", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (Busy !== 1'b0)
            $display("FAIL fifo_busy_end: Busy=%b expected 0", Busy);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef UART_TX_FIFO_EN
        test_basic_8n1();
        test_parity_stop();
        test_back_to_back();
        test_divisor();
        test_reset_mid_frame();
`else
        test_fifo();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
